// File: rtl/dmem_dump_sequencer.sv
// Post-run data-memory dump: walks a fixed BRAM address window one read at a time
// and presents each word, tagged with its address, to the display path for a dwell time.
module dmem_dump_sequencer #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 32,
    parameter int FIRST_ADDR   = 0,
    parameter int LAST_ADDR    = 9,
    parameter int READ_LATENCY = 2,
    parameter int DWELL_CYCLES = 100000
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  start_in,
    input  logic                  freeze_in,
    output logic                  rd_en_out,
    output logic [ADDR_WIDTH-1:0] rd_addr_out,
    input  logic [DATA_WIDTH-1:0] rd_data_in,
    output logic [31:0]           val_out,
    output logic                  val_valid_out,
    output logic                  busy_out,
    output logic                  wrap_out
);

    localparam int DW_W  = $clog2(DWELL_CYCLES + 1);
    localparam int LAT_W = $clog2(READ_LATENCY + 1);

    localparam logic [ADDR_WIDTH-1:0] ADDR_FIRST = ADDR_WIDTH'(FIRST_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(LAST_ADDR);
    localparam logic [DW_W-1:0]       DWELL_LAST = DW_W'(DWELL_CYCLES - 1);
    localparam logic [LAT_W-1:0]      LAT_LAST   = LAT_W'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t                state, state_next;
    logic                  start_latched;
    logic [ADDR_WIDTH-1:0] addr, addr_next;
    logic [LAT_W-1:0]      lat_cnt, lat_cnt_next;
    logic [DW_W-1:0]       dwell_cnt, dwell_cnt_next;
    logic                  capture;
    logic                  wrap_next;
    logic                  rd_en;
    logic [31:0]           val_q;
    logic                  val_valid_q;
    logic                  wrap_q;
    logic [15:0]           addr_tag;

    assign addr_tag = 16'(addr);

    // Only the low half of the BRAM word is shown; the remaining bits are deliberately dropped.
    generate
        if (DATA_WIDTH > 16) begin : g_drop_high
            logic unused_data_high;
            assign unused_data_high = ^rd_data_in[DATA_WIDTH-1:16];
        end
    endgenerate

    always_comb begin
        state_next     = state;
        addr_next      = addr;
        lat_cnt_next   = lat_cnt;
        dwell_cnt_next = dwell_cnt;
        capture        = 1'b0;
        wrap_next      = 1'b0;
        rd_en          = 1'b0;
        case (state)
            S_IDLE: begin
                lat_cnt_next   = '0;
                dwell_cnt_next = '0;
                if (start_latched) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                rd_en        = 1'b1;
                lat_cnt_next = '0;
                state_next   = S_WAIT;
            end
            S_WAIT: begin
                if (lat_cnt == LAT_LAST) begin
                    capture        = 1'b1;
                    dwell_cnt_next = '0;
                    state_next     = S_HOLD;
                end else begin
                    lat_cnt_next = lat_cnt + LAT_W'(1);
                end
            end
            S_HOLD: begin
                // Freeze only stalls the dwell count; reads in flight are never held back.
                if (!freeze_in) begin
                    if (dwell_cnt == DWELL_LAST) begin
                        dwell_cnt_next = '0;
                        state_next     = S_ISSUE;
                        if (addr == ADDR_LAST) begin
                            addr_next = ADDR_FIRST;
                            wrap_next = 1'b1;
                        end else begin
                            addr_next = addr + ADDR_WIDTH'(1);
                        end
                    end else begin
                        dwell_cnt_next = dwell_cnt + DW_W'(1);
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state         <= S_IDLE;
            start_latched <= 1'b0;
            addr          <= ADDR_FIRST;
            lat_cnt       <= '0;
            dwell_cnt     <= '0;
            val_q         <= '0;
            val_valid_q   <= 1'b0;
            wrap_q        <= 1'b0;
        end else begin
            state     <= state_next;
            addr      <= addr_next;
            lat_cnt   <= lat_cnt_next;
            dwell_cnt <= dwell_cnt_next;
            wrap_q    <= wrap_next;
            if (start_in) begin
                start_latched <= 1'b1;
            end
            if (capture) begin
                val_q       <= {addr_tag, rd_data_in[15:0]};
                val_valid_q <= 1'b1;
            end
        end
    end

    assign rd_en_out     = rd_en;
    assign rd_addr_out   = addr;
    assign val_out       = val_q;
    assign val_valid_out = val_valid_q;
    assign busy_out      = (state != S_IDLE);
    assign wrap_out      = wrap_q;

endmodule

// File: tb/tb_dmem_dump_sequencer.sv
// Directed bench for dmem_dump_sequencer: a 4-word scan window and a single-word window,
// each fed by a latency-2 BRAM model returning 0x1000+addr.
module tb_dmem_dump_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, start, freeze;
    logic        rd_en, val_valid, busy, wrap;
    logic [9:0]  rd_addr;
    logic [31:0] rd_data, val, pipe;

    logic        rst_n2, start2, freeze2;
    logic        rd_en2, val_valid2, busy2, wrap2;
    logic [9:0]  rd_addr2;
    logic [31:0] rd_data2, val2, pipe2;

    int total = 0;
    int bad   = 0;
    int n, w;

    always #5 clk = ~clk;

    dmem_dump_sequencer #(
        .ADDR_WIDTH(10), .DATA_WIDTH(32), .FIRST_ADDR(0), .LAST_ADDR(3),
        .READ_LATENCY(2), .DWELL_CYCLES(4)
    ) dut (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .freeze_in(freeze),
        .rd_en_out(rd_en), .rd_addr_out(rd_addr), .rd_data_in(rd_data),
        .val_out(val), .val_valid_out(val_valid), .busy_out(busy), .wrap_out(wrap)
    );

    dmem_dump_sequencer #(
        .ADDR_WIDTH(10), .DATA_WIDTH(32), .FIRST_ADDR(5), .LAST_ADDR(5),
        .READ_LATENCY(2), .DWELL_CYCLES(4)
    ) dut_single (
        .clk_in(clk), .rst_n_in(rst_n2), .start_in(start2), .freeze_in(freeze2),
        .rd_en_out(rd_en2), .rd_addr_out(rd_addr2), .rd_data_in(rd_data2),
        .val_out(val2), .val_valid_out(val_valid2), .busy_out(busy2), .wrap_out(wrap2)
    );

    // Two-stage BRAM model; data is only meaningful READ_LATENCY cycles after an enabled read.
    always @(posedge clk) begin
        pipe     <= rd_en ? (32'h1000 + 32'(rd_addr)) : 32'hBAD0_0BAD;
        rd_data  <= pipe;
        pipe2    <= rd_en2 ? (32'h1000 + 32'(rd_addr2)) : 32'hBAD0_0BAD;
        rd_data2 <= pipe2;
    end

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic f);
        rst_n  = r;
        start  = s;
        freeze = f;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Steps until the selected DUT issues a read (bounded), counting edges and wrap pulses seen.
    task automatic runUntilIssue(input bit sel, input int maxc, output int cnt, output int wraps);
        cnt   = 0;
        wraps = 0;
        do begin
            stepClock();
            cnt++;
            if ((sel ? wrap2 : wrap) === 1'b1) wraps++;
        end while ((sel ? rd_en2 : rd_en) !== 1'b1 && cnt < maxc);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_rden"}, 32'(rd_en), 32'd0);
        checkOutput({tag, "_addr"}, 32'(rd_addr), 32'd0);
        checkOutput({tag, "_val"}, val, 32'd0);
        checkOutput({tag, "_valid"}, 32'(val_valid), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_wrap"}, 32'(wrap), 32'd0);
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0);
        rst_n2  = 1'b0;
        start2  = 1'b0;
        freeze2 = 1'b0;
        repeat (3) stepClock();
        checkReset("reset");

        applyStimulus(1'b1, 1'b0, 1'b0);
        rst_n2 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            stepClock();
            checkOutput("idle_rden", 32'(rd_en), 32'd0);
            checkOutput("idle_busy", 32'(busy), 32'd0);
            checkOutput("idle_val", val, 32'd0);
            checkOutput("idle_valid", 32'(val_valid), 32'd0);
        end

        $display("[TB] start pulse");
        applyStimulus(1'b1, 1'b1, 1'b0);
        stepClock();
        checkOutput("latch_edge_rden", 32'(rd_en), 32'd0);
        checkOutput("latch_edge_busy", 32'(busy), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        stepClock();
        checkOutput("first_rden", 32'(rd_en), 32'd1);
        checkOutput("first_addr", 32'(rd_addr), 32'd0);
        checkOutput("first_busy", 32'(busy), 32'd1);

        $display("[TB] full scan and wrap");
        for (int k = 0; k < 4; k++) begin
            repeat (3) stepClock();
            checkOutput("scan_val", val, 32'h1000 + (32'(k) << 16) + 32'(k));
            checkOutput("scan_valid", 32'(val_valid), 32'd1);
            checkOutput("scan_rden_hold", 32'(rd_en), 32'd0);
            runUntilIssue(1'b0, 20, n, w);
            checkOutput("scan_period", 32'(n + 3), 32'd7);
            checkOutput("scan_next_addr", 32'(rd_addr), 32'((k + 1) % 4));
            checkOutput("scan_wraps", 32'(w), (k == 3) ? 32'd1 : 32'd0);
            checkOutput("scan_wrap_now", 32'(wrap), (k == 3) ? 32'd1 : 32'd0);
        end

        repeat (3) stepClock();
        checkOutput("rescan_val0", val, 32'h0000_1000);
        runUntilIssue(1'b0, 20, n, w);
        checkOutput("rescan_addr1", 32'(rd_addr), 32'd1);

        $display("[TB] freeze in hold");
        repeat (3) stepClock();
        checkOutput("pre_freeze_val", val, 32'h0001_1001);
        stepClock();
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            stepClock();
            checkOutput("freeze_val", val, 32'h0001_1001);
            checkOutput("freeze_rden", 32'(rd_en), 32'd0);
            checkOutput("freeze_busy", 32'(busy), 32'd1);
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        runUntilIssue(1'b0, 20, n, w);
        checkOutput("freeze_remaining", 32'(n), 32'd3);
        checkOutput("freeze_next_addr", 32'(rd_addr), 32'd2);

        $display("[TB] freeze in wait");
        applyStimulus(1'b1, 1'b0, 1'b1);
        repeat (3) stepClock();
        checkOutput("wait_freeze_val", val, 32'h0002_1002);
        checkOutput("wait_freeze_valid", 32'(val_valid), 32'd1);
        repeat (2) stepClock();
        checkOutput("wait_freeze_rden", 32'(rd_en), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        runUntilIssue(1'b0, 20, n, w);
        checkOutput("wait_freeze_dwell", 32'(n), 32'd4);
        checkOutput("wait_freeze_addr", 32'(rd_addr), 32'd3);

        runUntilIssue(1'b0, 20, n, w);
        checkOutput("wrap2_period", 32'(n), 32'd7);
        checkOutput("wrap2_addr", 32'(rd_addr), 32'd0);
        checkOutput("wrap2_wraps", 32'(w), 32'd1);
        runUntilIssue(1'b0, 20, n, w);
        checkOutput("a1_addr", 32'(rd_addr), 32'd1);
        checkOutput("a1_wraps", 32'(w), 32'd0);
        runUntilIssue(1'b0, 20, n, w);
        checkOutput("a2_addr", 32'(rd_addr), 32'd2);

        $display("[TB] reset mid-read");
        stepClock();
        applyStimulus(1'b0, 1'b0, 1'b0);
        stepClock();
        checkReset("midreset");
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            stepClock();
            checkOutput("post_reset_val", val, 32'd0);
            checkOutput("post_reset_valid", 32'(val_valid), 32'd0);
            checkOutput("post_reset_rden", 32'(rd_en), 32'd0);
            checkOutput("post_reset_busy", 32'(busy), 32'd0);
        end
        applyStimulus(1'b1, 1'b1, 1'b0);
        stepClock();
        applyStimulus(1'b1, 1'b0, 1'b0);
        stepClock();
        checkOutput("restart_rden", 32'(rd_en), 32'd1);
        checkOutput("restart_addr", 32'(rd_addr), 32'd0);
        repeat (3) stepClock();
        checkOutput("restart_val", val, 32'h0000_1000);

        $display("[TB] single-word window");
        checkOutput("single_idle_busy", 32'(busy2), 32'd0);
        start2 = 1'b1;
        stepClock();
        start2 = 1'b0;
        stepClock();
        checkOutput("single_rden", 32'(rd_en2), 32'd1);
        checkOutput("single_addr", 32'(rd_addr2), 32'd5);
        checkOutput("single_first_wrap", 32'(wrap2), 32'd0);
        for (int p = 0; p < 3; p++) begin
            repeat (3) stepClock();
            checkOutput("single_val", val2, 32'h0005_1005);
            runUntilIssue(1'b1, 20, n, w);
            checkOutput("single_period", 32'(n + 3), 32'd7);
            checkOutput("single_addr_again", 32'(rd_addr2), 32'd5);
            checkOutput("single_wraps", 32'(w), 32'd1);
            checkOutput("single_wrap_now", 32'(wrap2), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
